// File: rtl/bin2bcd_arb.sv
// rtl/bin2bcd_arb.sv - round-robin arbiter sharing one pipelined bin2bcd converter
module bin2bcd_arb #(
    parameter int NREQ      = 4,
    parameter int TAG_DEPTH = 8,
    parameter int IDW       = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NREQ-1:0]            req_vld,
    input  logic [NREQ*11-1:0]         req_bin,
    output logic [NREQ-1:0]            req_rdy,
    output logic [10:0]                cvt_bin,
    output logic                       cvt_vld,
    input  logic [16:0]                cvt_bcd,
    input  logic                       cvt_bcd_vld,
    output logic [16:0]                rsp_bcd,
    output logic [NREQ-1:0]            rsp_vld,
    output logic                       range_err,
    output logic                       tag_err,
    output logic [$clog2(TAG_DEPTH):0] outstanding
);

    localparam int AW = $clog2(TAG_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(TAG_DEPTH);
    localparam logic [10:0] NEG_MIN = 11'h400;

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gnt_id;
    logic [NREQ-1:0] gnt;
    logic [10:0]     gnt_word;
    logic            can_issue;
    logic            xfer;
    logic            pop;
    logic            fifo_empty;
    int              idx;

    logic [IDW-1:0]  tag_mem [TAG_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // Credit check uses the registered count only, so a full FIFO blocks issue
    // even when a result pops in the same cycle.
    always_comb begin
        gnt       = '0;
        gnt_id    = '0;
        gnt_word  = '0;
        idx       = 0;
        can_issue = (outstanding < FULL_CNT);
        if (can_issue && rstn) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (int'(ptr) + k) % NREQ;
                if ((gnt == '0) && req_vld[idx]) begin
                    gnt[idx] = 1'b1;
                    gnt_id   = IDW'(idx);
                    gnt_word = req_bin[idx*11 +: 11];
                end
            end
        end
    end

    assign req_rdy    = gnt;
    assign xfer       = |gnt;
    assign fifo_empty = (outstanding == '0);
    assign pop        = cvt_bcd_vld && !fifo_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr       <= IDW'(NREQ - 1);
            cvt_vld   <= 1'b0;
            cvt_bin   <= '0;
            range_err <= 1'b0;
        end else begin
            cvt_vld   <= xfer;
            range_err <= xfer && (gnt_word == NEG_MIN);
            if (xfer) begin
                ptr     <= gnt_id;
                cvt_bin <= (gnt_word == NEG_MIN) ? 11'h000 : gnt_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            tag_mem[wr_ptr] <= gnt_id;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            rsp_vld     <= '0;
            rsp_bcd     <= '0;
            tag_err     <= 1'b0;
        end else begin
            if (xfer) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rsp_vld <= NREQ'(1) << tag_mem[rd_ptr];
                rsp_bcd <= cvt_bcd;
            end else begin
                rsp_vld <= '0;
            end
            case ({xfer, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (cvt_bcd_vld && fifo_empty) begin
                tag_err <= 1'b1;
            end
        end
    end

endmodule
